// File: rtl/hex_display_ctrl_pkg.sv
// Shared widths, blank pattern and FSM state type for the hex display controller.
package hex_display_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/hex_display_ctrl_dec.sv
// Hex nibble to active-low 7-segment pattern decoder (segment g is the MSB).
module hexTo7Seg
    import hex_display_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h27;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Time-multiplexed hex display controller: one shared decoder scans digits MSB first.
// Optional blink of all digits when HEX_BLINK_EN is defined.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 1
`ifdef HEX_BLINK_EN
   ,parameter int unsigned BLINK_DIV  = 25000000
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NIB_W*NUM_DIGITS-1:0] value,
    input  logic                        blank_lz,
    input  logic                        valid,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out
`ifdef HEX_BLINK_EN
   ,input  logic                        blink_en
`endif
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx;
    logic [SLOT_W-1:0]             slot;
    logic                          seen_nz;
    logic [NIB_W*NUM_DIGITS-1:0]   shadow;
    logic                          shadow_lz;
    logic [SEG_W*NUM_DIGITS-1:0]   digits;
    logic [NIB_W-1:0]              nibble;
    logic [SEG_W-1:0]              seg;
    logic                          slot_end;
    logic                          last_digit;
    logic                          blank_digit;

    assign nibble      = shadow[idx*NIB_W +: NIB_W];
    assign slot_end    = (slot == SLOT_LAST);
    assign last_digit  = (idx == '0);
    assign blank_digit = shadow_lz && (nibble == '0) && !seen_nz && !last_digit;

    hexTo7Seg u_dec (
        .hex (nibble),
        .seg (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (slot_end && last_digit) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= IDX_TOP;
            slot      <= '0;
            seen_nz   <= 1'b0;
            shadow    <= '0;
            shadow_lz <= 1'b0;
            digits    <= '1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && valid) begin
                shadow    <= value;
                shadow_lz <= blank_lz;
                idx       <= IDX_TOP;
                slot      <= '0;
                seen_nz   <= 1'b0;
            end else if (state == SCAN) begin
                if (slot_end) begin
                    slot <= '0;
                    digits[idx*SEG_W +: SEG_W] <= blank_digit ? SEG_BLANK : seg;
                    seen_nz <= seen_nz | (nibble != '0);
                    if (last_digit) done <= 1'b1;
                    else            idx  <= idx - 1'b1;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
        end
    end

`ifdef HEX_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0] blk_cnt;
    logic             phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // Blanking only masks the pins; the digit registers keep their contents.
    assign hex_out = (blink_en && !phase) ? '1 : digits;
`else
    assign hex_out = digits;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: vector table, random vs. reference model, corner sequences.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] value = '0;
    logic        blank_lz = 1'b0;
    logic        valid = 1'b0;
    logic        valid4 = 1'b0;
    logic        ready, busy, done;
    logic        ready4, busy4, done4;
    logic [41:0] hex_out, hex_out4;
`ifdef HEX_BLINK_EN
    logic        blink_en = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int unsigned kcyc;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) kcyc <= 0;
        else       kcyc <= kcyc + 1;

    hex_display_ctrl #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (1)
`ifdef HEX_BLINK_EN
       ,.BLINK_DIV  (8)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .blank_lz (blank_lz),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .hex_out  (hex_out)
`ifdef HEX_BLINK_EN
       ,.blink_en (blink_en)
`endif
    );

    hex_display_ctrl #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (4)
`ifdef HEX_BLINK_EN
       ,.BLINK_DIV  (8)
`endif
    ) dut4 (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .blank_lz (blank_lz),
        .valid    (valid4),
        .ready    (ready4),
        .busy     (busy4),
        .done     (done4),
        .hex_out  (hex_out4)
`ifdef HEX_BLINK_EN
       ,.blink_en (1'b0)
`endif
    );

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Reference: strip the leading-zero run (never digit 0), decode the rest.
    function automatic logic [41:0] model(input logic [23:0] v, input logic lz);
        logic [41:0] r;
        bit          leading;
        logic [3:0]  nib;
        r = '1;
        leading = lz;
        for (int i = 5; i >= 0; i--) begin
            nib = v[i*4 +: 4];
            if (leading && nib == 4'h0 && i != 0) r[i*7 +: 7] = 7'h7F;
            else begin
                r[i*7 +: 7] = seg_tbl[nib];
                leading = 0;
            end
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_scan(input logic [23:0] v, input logic lz, input bit use4, output int edges);
        int n;
        n = 0;
        @(negedge clk);
        while (!(use4 ? ready4 : ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        value = v;
        blank_lz = lz;
        if (use4) valid4 = 1'b1; else valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        valid4 = 1'b0;
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (use4 ? done4 : done) break;
        end
    endtask

    typedef struct {
        logic [23:0] v;
        logic        lz;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          edges;
        int          wr_edge [6];
        int          done_edge;
        int          n;
        logic [23:0] rv;
        logic        rlz;

        tbl[0] = '{24'h00A05F, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h0E}};
        tbl[1] = '{24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[2] = '{24'h000000, 1'b0, {6{7'h40}}};
        tbl[3] = '{24'h123456, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        tbl[4] = '{24'h89ABCD, 1'b1, {7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21}};
        tbl[5] = '{24'h00EF70, 1'b1, {7'h7F, 7'h7F, 7'h06, 7'h0E, 7'h78, 7'h40}};
        tbl[6] = '{24'h000001, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};

        // Reset state
        #12;
        check("rst_hex", 64'(hex_out), 64'({6{7'h7F}}));
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hex4", 64'(hex_out4), 64'({6{7'h7F}}));
        @(negedge clk);
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            run_scan(tbl[i].v, tbl[i].lz, 1'b0, edges);
            check($sformatf("tbl%0d_latency", i), 64'(edges), 64'd6);
            check($sformatf("tbl%0d_hex", i), 64'(hex_out), 64'(tbl[i].exp));
        end

        // Randomized values, biased towards leading zeros
        for (int i = 0; i < 24; i++) begin
            rv = 24'($urandom);
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) rv[(5-j)*4 +: 4] = 4'h0;
            if ($urandom_range(0, 3) == 0) rv[11:8] = 4'h0;
            rlz = 1'($urandom_range(0, 1));
            run_scan(rv, rlz, 1'b0, edges);
            check("rand_latency", 64'(edges), 64'd6);
            check($sformatf("rand_hex_%h_%0d", rv, rlz), 64'(hex_out), 64'(model(rv, rlz)));
        end

        // Back-to-back: valid held across the done cycle
        @(negedge clk);
        value = 24'h111111;
        blank_lz = 1'b0;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        value = 24'h222222;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", 64'(done), 64'd1);
        check("b2b_done_ready", 64'(ready), 64'd1);
        check("b2b_first_hex", 64'(hex_out), 64'({6{7'h79}}));
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("b2b_accept_in_done", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_partial", 64'(hex_out), 64'({7'h24, {5{7'h79}}}));
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_final_hex", 64'(hex_out), 64'({6{7'h24}}));

        // Reset in the middle of a scan
        @(negedge clk);
        value = 24'h123456;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_hex", 64'(hex_out), 64'({6{7'h7F}}));
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // SCAN_DIV=4: digits written 4 edges apart, MSB first
        for (int d = 0; d < 6; d++) wr_edge[d] = -1;
        done_edge = -1;
        @(negedge clk);
        value = 24'hFEDCBA;
        blank_lz = 1'b0;
        valid4 = 1'b1;
        @(posedge clk);
        #1 valid4 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 6; d++)
                if (wr_edge[d] < 0 && hex_out4[d*7 +: 7] != 7'h7F) wr_edge[d] = e;
            if (done4) begin
                done_edge = e;
                break;
            end
        end
        for (int j = 0; j < 6; j++)
            check($sformatf("div4_digit%0d_edge", 5 - j), 64'(wr_edge[5-j]), 64'(4 * (j + 1)));
        check("div4_done_edge", 64'(done_edge), 64'd24);
        check("div4_hex", 64'(hex_out4), 64'({7'h0E, 7'h06, 7'h21, 7'h27, 7'h03, 7'h08}));

        for (int i = 0; i < 4; i++) begin
            rv = 24'($urandom);
            rv[23:16] = 8'h00;
            rlz = 1'($urandom_range(0, 1));
            run_scan(rv, rlz, 1'b1, edges);
            check("div4_rand_latency", 64'(edges), 64'd24);
            check("div4_rand_hex", 64'(hex_out4), 64'(model(rv, rlz)));
        end

`ifdef HEX_BLINK_EN
        // Blink phase follows cycles since reset: on for 8, off for 8
        run_scan(24'h000001, 1'b1, 1'b0, edges);
        blink_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("blink_hex", 64'(hex_out),
                  (((kcyc / 8) % 2) == 0) ? 64'(model(24'h000001, 1'b1)) : 64'({6{7'h7F}}));
        end
        blink_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("blink_off_hex", 64'(hex_out), 64'(model(24'h000001, 1'b1)));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
